// File: rtl/host_packet_engine.sv
// host_packet_engine: parses the UART host byte stream (command, 16-bit LE
// address, optional data burst) into write/read transactions on the CPU
// memories, streams read words back low byte first, and flags timeouts,
// invalid targets and dropped rx bytes.
module host_packet_engine #(
    parameter int NUM_TARGETS    = 8,
    parameter int WORD_BYTES     = 12,
    parameter int ADDR_W         = 12,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [3:0]              mem_target,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_BYTES*8-1:0] mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [WORD_BYTES*8-1:0] mem_rdata,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_target,
    output logic                    err_overrun
);

    localparam int WW    = WORD_BYTES * 8;
    localparam int BC_W  = $clog2(WORD_BYTES + 1);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0] NT = 5'(NUM_TARGETS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_WDATA, S_WSTROBE, S_RREQ, S_RWAIT, S_RSEND
    } state_t;

    state_t            state_q, state_d;
    logic              is_read_q, is_read_d;
    logic              bad_tgt_q, bad_tgt_d;
    logic [2:0]        words_q, words_d;      // words remaining after the current one
    logic [3:0]        target_q, target_d;
    logic [7:0]        addr_lo_q, addr_lo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WW-1:0]     data_q, data_d;        // write assembly / read shift register
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_target_q, err_target_d;
    logic              err_overrun_q, err_overrun_d;

    logic        last_byte;
    logic        timed_out;
    logic [15:0] addr_full;

    assign last_byte = (byte_cnt_q == BC_W'(WORD_BYTES - 1));
    assign timed_out = !rx_valid && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign addr_full = {rx_data, addr_lo_q};

    // State and datapath registers; reset discards any partial packet.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses <= so every register samples the pre-edge values.
        if (rst_in) begin
            state_q       <= S_IDLE;
            is_read_q     <= 1'b0;
            bad_tgt_q     <= 1'b0;
            words_q       <= '0;
            target_q      <= '0;
            addr_lo_q     <= '0;
            addr_q        <= '0;
            byte_cnt_q    <= '0;
            data_q        <= '0;
            lat_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
            err_target_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_read_q     <= is_read_d;
            bad_tgt_q     <= bad_tgt_d;
            words_q       <= words_d;
            target_q      <= target_d;
            addr_lo_q     <= addr_lo_d;
            addr_q        <= addr_d;
            byte_cnt_q    <= byte_cnt_d;
            data_q        <= data_d;
            lat_cnt_q     <= lat_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_target_q  <= err_target_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Next-state logic: packet parsing, burst sequencing, timeout and overrun.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        is_read_d     = is_read_q;
        bad_tgt_d     = bad_tgt_q;
        words_d       = words_q;
        target_d      = target_q;
        addr_lo_d     = addr_lo_q;
        addr_d        = addr_q;
        byte_cnt_d    = byte_cnt_q;
        data_d        = data_q;
        lat_cnt_d     = lat_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        err_timeout_d = 1'b0;
        err_target_d  = 1'b0;
        err_overrun_d = 1'b0;

        // Inter-byte timeout only guards the host-driven phases of a packet.
        if (state_q == S_ADDR_LO || state_q == S_ADDR_HI || state_q == S_WDATA) begin
            if (rx_valid) begin
                idle_cnt_d = '0;
            end else if (timed_out) begin
                idle_cnt_d    = '0;
                err_timeout_d = 1'b1;
                byte_cnt_d    = '0;
                data_d        = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end

        // The host cannot be stalled, so bytes arriving during a read are lost.
        if ((state_q == S_RREQ || state_q == S_RWAIT || state_q == S_RSEND) && rx_valid) begin
            err_overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    is_read_d    = rx_data[7];
                    words_d      = rx_data[6:4];
                    target_d     = rx_data[3:0];
                    bad_tgt_d    = ({1'b0, rx_data[3:0]} >= NT);
                    err_target_d = ({1'b0, rx_data[3:0]} >= NT);
                    idle_cnt_d   = '0;
                    byte_cnt_d   = '0;
                    state_d      = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (timed_out) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    addr_lo_d = rx_data;
                    state_d   = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                if (timed_out) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    addr_d  = addr_full[ADDR_W-1:0];
                    state_d = is_read_q ? S_RREQ : S_WDATA;
                end
            end
            S_WDATA: begin
                if (timed_out) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (byte_cnt_q == BC_W'(i)) data_d[i*8 +: 8] = rx_data;
                    end
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = S_WSTROBE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            S_WSTROBE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (words_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    words_d = words_q - 3'd1;
                    state_d = S_WDATA;
                end
            end
            S_RREQ: begin
                lat_cnt_d = LAT_W'(1);
                state_d   = S_RWAIT;
            end
            S_RWAIT: begin
                if (lat_cnt_q == LAT_W'(READ_LATENCY)) begin
                    data_d     = bad_tgt_q ? '0 : mem_rdata;
                    byte_cnt_d = '0;
                    state_d    = S_RSEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_RSEND: begin
                if (tx_ready) begin
                    data_d = data_q >> 8;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        addr_d     = addr_q + ADDR_W'(1);
                        if (words_q == 3'd0) begin
                            state_d = S_IDLE;
                        end else begin
                            words_d = words_q - 3'd1;
                            state_d = S_RREQ;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_we      = (state_q == S_WSTROBE) && !bad_tgt_q;
    assign mem_re      = (state_q == S_RREQ) && !bad_tgt_q;
    assign tx_valid    = (state_q == S_RSEND);
    assign tx_data     = data_q[7:0];
    assign mem_target  = target_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = data_q;
    assign err_timeout = err_timeout_q;
    assign err_target  = err_target_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_host_packet_engine.sv
// tb_host_packet_engine: scoreboard bench; expected writes and tx bytes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_host_packet_engine;

    localparam int NT = 8;
    localparam int WB = 12;
    localparam int AW = 12;
    localparam int RL = 2;
    localparam int TO = 200;
    localparam int WW = WB * 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic [3:0]    mem_target;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [WW-1:0] mem_rdata;
    logic          busy;
    logic          err_timeout;
    logic          err_target;
    logic          err_overrun;

    host_packet_engine #(
        .NUM_TARGETS(NT), .WORD_BYTES(WB), .ADDR_W(AW),
        .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_target(mem_target), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .busy(busy), .err_timeout(err_timeout), .err_target(err_target),
        .err_overrun(err_overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]    tgt;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int last_rx_cyc = 0;
    int re_cyc   = 0;
    int we_cnt = 0, re_cnt = 0, to_cnt = 0, tgt_cnt = 0, ovr_cnt = 0;
    bit lat_chk  = 1'b0;
    logic       tx_v_prev = 1'b0, tx_r_prev = 1'b0;
    logic [7:0] tx_d_prev = 8'h00;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents seen on reads: byte i of word a is i+1+13*a.
    function automatic logic [WW-1:0] pat(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        for (int i = 0; i < WB; i++) w[i*8 +: 8] = 8'(i + 1 + 13 * int'(a));
        return w;
    endfunction

    // Read-latency model: data for the mem_re cycle appears RL cycles later.
    logic [WW-1:0] pipe [RL];
    always @(posedge clk_in) begin
        for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= mem_re ? pat(mem_addr) : '0;
    end
    assign mem_rdata = pipe[RL-1];

    always @(posedge clk_in) cyc++;

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk_in) begin
        if (rst_in) begin
            tx_v_prev = 1'b0;
            tx_r_prev = 1'b0;
        end else begin
            if (mem_we) begin
                we_cnt++;
                check("we_latency", 128'(cyc - last_rx_cyc), 128'(1));
                if (exp_wr.size() == 0) begin
                    check("we_unexpected", 128'(1), 128'(0));
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("we_target", 128'(mem_target), 128'(e.tgt));
                    check("we_addr", 128'(mem_addr), 128'(e.addr));
                    check("we_data", 128'(mem_wdata), 128'(e.data));
                end
            end
            if (mem_re) begin
                re_cnt++;
                re_cyc = cyc;
            end
            if (tx_valid && !tx_v_prev && lat_chk)
                check("tx_latency", 128'(cyc - re_cyc), 128'(RL + 1));
            if (tx_v_prev && !tx_r_prev)
                check("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, tx_d_prev}));
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 128'(1), 128'(0));
                end else begin
                    logic [7:0] b;
                    b = exp_tx.pop_front();
                    check("tx_byte", 128'(tx_data), 128'(b));
                end
            end
            if (err_timeout) begin
                to_cnt++;
                check("timeout_delay_in_range",
                      128'((cyc - last_rx_cyc >= TO) && (cyc - last_rx_cyc <= TO + 2)), 128'(1));
            end
            if (err_target) begin
                tgt_cnt++;
                check("err_target_cycle", 128'(cyc - last_rx_cyc), 128'(1));
            end
            if (err_overrun) begin
                ovr_cnt++;
                check("err_overrun_cycle", 128'(cyc - last_rx_cyc), 128'(1));
            end
            if (rx_valid) last_rx_cyc = cyc;
            tx_v_prev = tx_valid;
            tx_r_prev = tx_ready;
            tx_d_prev = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk_in); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a);
        send_byte(cmd);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
    endtask

    task automatic send_word(input logic [WW-1:0] d);
        for (int i = 0; i < WB; i++) send_byte(d[i*8 +: 8]);
    endtask

    task automatic push_wr(input logic [3:0] t, input logic [AW-1:0] a, input logic [WW-1:0] d);
        wr_t e;
        e.tgt = t; e.addr = a; e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_read(input logic [AW-1:0] a, input int nwords, input bit bad);
        logic [WW-1:0] w;
        logic [AW-1:0] aa;
        aa = a;
        for (int k = 0; k < nwords; k++) begin
            w = bad ? '0 : pat(aa);
            for (int i = 0; i < WB; i++) exp_tx.push_back(w[i*8 +: 8]);
            aa = aa + AW'(1);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk_in);
        while (busy && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        if (busy) check(tag, 128'(0), 128'(1));
        repeat (2) @(negedge clk_in);
        check("wr_queue_drained", 128'(exp_wr.size()), 128'(0));
        check("tx_queue_drained", 128'(exp_tx.size()), 128'(0));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({tx_valid, tx_data, mem_target, mem_addr, mem_wdata,
                     mem_we, mem_re, busy, err_timeout, err_target, err_overrun});
    endfunction

    initial begin
        logic [WW-1:0] w0, w1, d;
        int we0, re0, hs;

        // Reset state.
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_outputs", all_outs(), 128'(0));
        rst_in = 1'b0;

        // Write burst: 2 words at addr 1, target 0, bytes 0x00..0x17.
        for (int i = 0; i < WB; i++) begin
            w0[i*8 +: 8] = 8'(i);
            w1[i*8 +: 8] = 8'(i + WB);
        end
        push_wr(4'd0, 12'h001, w0);
        push_wr(4'd0, 12'h002, w1);
        we0 = we_cnt;
        send_byte(8'h10);
        check("busy_after_cmd", 128'(busy), 128'(1));
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(w0);
        send_word(w1);
        wait_idle("wait_write_burst", 100);
        check("write_burst_we_count", 128'(we_cnt - we0), 128'(2));

        // Read 1 word from target 7 with a 5-cycle tx stall mid-word.
        re0 = re_cnt;
        lat_chk = 1'b1;
        push_read(12'h000, 1, 1'b0);
        send_hdr(8'h87, 16'h0000);
        hs = 0;
        for (int k = 0; k < 200 && hs < 3; k++) begin
            @(negedge clk_in);
            if (tx_valid && tx_ready) hs++;
        end
        if (hs < 3) check("wait_read_handshakes", 128'(0), 128'(1));
        @(posedge clk_in); #1;
        tx_ready = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        tx_ready = 1'b1;
        wait_idle("wait_read", 200);
        check("read_re_count", 128'(re_cnt - re0), 128'(1));

        // Two-word read across the address wrap (0xFFF -> 0x000), target 5.
        re0 = re_cnt;
        push_read(12'hFFF, 2, 1'b0);
        send_hdr(8'h95, 16'h0FFF);
        wait_idle("wait_read_wrap", 200);
        check("read_wrap_re_count", 128'(re_cnt - re0), 128'(2));
        lat_chk = 1'b0;

        // Write wrap; high address bits above ADDR_W are ignored.
        we0 = we_cnt;
        w0 = {$urandom, $urandom, $urandom};
        w1 = {$urandom, $urandom, $urandom};
        push_wr(4'd3, 12'hFFF, w0);
        push_wr(4'd3, 12'h000, w1);
        send_hdr(8'h13, 16'hFFFF);
        send_word(w0);
        send_word(w1);
        wait_idle("wait_write_wrap", 100);
        check("write_wrap_we_count", 128'(we_cnt - we0), 128'(2));

        // Timeout mid-word: no write, then a normal packet.
        we0 = we_cnt;
        send_hdr(8'h00, 16'h0005);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        wait_idle("wait_timeout", TO + 50);
        check("timeout_pulses", 128'(to_cnt), 128'(1));
        check("timeout_no_write", 128'(we_cnt - we0), 128'(0));
        d = {$urandom, $urandom, $urandom};
        push_wr(4'd1, 12'h010, d);
        send_hdr(8'h01, 16'h0010);
        send_word(d);
        wait_idle("wait_after_timeout", 100);
        check("after_timeout_we_count", 128'(we_cnt - we0), 128'(1));

        // Invalid-target read with an rx byte injected during RSEND.
        re0 = re_cnt;
        push_read(12'h022, 1, 1'b1);
        send_hdr(8'h89, 16'h0022);
        for (int k = 0; k < 50 && !tx_valid; k++) @(negedge clk_in);
        if (!tx_valid) check("wait_bad_read_tx", 128'(0), 128'(1));
        send_byte(8'h55);
        wait_idle("wait_bad_read", 200);
        check("bad_read_err_target", 128'(tgt_cnt), 128'(1));
        check("bad_read_no_re", 128'(re_cnt - re0), 128'(0));
        check("overrun_pulses", 128'(ovr_cnt), 128'(1));

        // Invalid-target write: data consumed, no strobe.
        we0 = we_cnt;
        send_hdr(8'h0A, 16'h0040);
        send_word({$urandom, $urandom, $urandom});
        wait_idle("wait_bad_write", 100);
        check("bad_write_err_target", 128'(tgt_cnt), 128'(2));
        check("bad_write_no_we", 128'(we_cnt - we0), 128'(0));

        // Reset mid-write, then a complete packet.
        send_hdr(8'h02, 16'h0030);
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        #1;
        check("midwrite_reset_outputs", all_outs(), 128'(0));
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        we0 = we_cnt;
        d = {$urandom, $urandom, $urandom};
        push_wr(4'd2, 12'h031, d);
        send_hdr(8'h02, 16'h0031);
        send_word(d);
        wait_idle("wait_after_reset", 100);
        check("after_reset_we_count", 128'(we_cnt - we0), 128'(1));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule
